// File: rtl/vita49_timestamp_if.sv
// rtl/vita49_timestamp_if.sv - TSI load request and timestamp/lock status bundle
interface vita49_timestamp_if #(
   parameter int TSI_WIDTH = 32,
   parameter int TSF_WIDTH = 64
);
   logic                 tsi_load_valid;
   logic [TSI_WIDTH-1:0] tsi_load_data;
   logic [TSI_WIDTH-1:0] tsi;
   logic [TSF_WIDTH-1:0] tsf;
   logic                 ts_valid;
   logic                 pps_locked;
   logic                 pps_pulse;
   logic                 pps_missed;
   logic                 load_pending;

   modport master (
      input  tsi_load_valid, tsi_load_data,
      output tsi, tsf, ts_valid, pps_locked, pps_pulse, pps_missed, load_pending
   );

   modport slave (
      output tsi_load_valid, tsi_load_data,
      input  tsi, tsf, ts_valid, pps_locked, pps_pulse, pps_missed, load_pending
   );
endinterface

// File: rtl/vita49_timestamp.sv
// rtl/vita49_timestamp.sv - PPS-disciplined TSI/TSF timestamp generator with lock tracking
module vita49_timestamp #(
   parameter int TSI_WIDTH   = 32,
   parameter int TSF_WIDTH   = 64,
   parameter int SYNC_STAGES = 2,
   parameter int PPS_TIMEOUT = 150
) (
   input  logic               axis_clk,
   input  logic               axis_aresetn,
   input  logic               pps_in,
   input  logic               samp_en,
   vita49_timestamp_if.master ts
);
   localparam int CNT_W = $clog2(PPS_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PPS_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PPS_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_ACQUIRE,
      ST_LOCKED,
      ST_HOLDOVER
   } state_t;

   state_t               state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 hist_q;
   logic                 pps_edge;
   logic                 timeout;
   logic                 missed_d;
   logic [CNT_W-1:0]     period_q;
   logic [TSI_WIDTH-1:0] tsi_q, pend_q;
   logic [TSF_WIDTH-1:0] tsf_q;
   logic                 pending_q, pulse_q, missed_q;

   assign pps_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
   // Fires only on the cycle the saturating counter first reaches the limit.
   assign timeout  = !pps_edge && (period_q == CNT_LAST);

   always_ff @(posedge axis_clk) begin
      if (!axis_aresetn) begin
         sync_q    <= '0;
         hist_q    <= 1'b0;
         pulse_q   <= 1'b0;
         missed_q  <= 1'b0;
         period_q  <= '0;
         state_q   <= ST_UNLOCKED;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], pps_in};
         hist_q    <= sync_q[SYNC_STAGES-1];
         pulse_q   <= pps_edge;
         missed_q  <= missed_d;
         state_q   <= state_d;
         if (pps_edge)
            period_q <= '0;
         else if (period_q != CNT_MAX)
            period_q <= period_q + CNT_W'(1);
      end
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_aresetn) begin
         tsi_q     <= '0;
         tsf_q     <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         if (pps_edge) begin
            tsi_q <= pending_q ? pend_q : tsi_q + TSI_WIDTH'(1);
            tsf_q <= '0;
         end else if (samp_en) begin
            tsf_q <= tsf_q + TSF_WIDTH'(1);
         end
         // A load coinciding with PPS arms for the following second.
         if (ts.tsi_load_valid) begin
            pend_q    <= ts.tsi_load_data;
            pending_q <= 1'b1;
         end else if (pps_edge) begin
            pending_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      missed_d = 1'b0;
      case (state_q)
         ST_UNLOCKED: begin
            if (pps_edge) state_d = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (pps_edge) begin
               state_d = ST_LOCKED;
            end else if (timeout) begin
               state_d  = ST_UNLOCKED;
               missed_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (timeout) begin
               state_d  = ST_HOLDOVER;
               missed_d = 1'b1;
            end
         end
         ST_HOLDOVER: begin
            if (pps_edge) state_d = ST_LOCKED;
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   assign ts.tsi          = tsi_q;
   assign ts.tsf          = tsf_q;
   assign ts.load_pending = pending_q;
   assign ts.pps_pulse    = pulse_q;
   assign ts.pps_missed   = missed_q;
   assign ts.pps_locked   = (state_q == ST_LOCKED);
   assign ts.ts_valid     = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
endmodule

// File: tb/tb_vita49_timestamp.sv
// tb/tb_vita49_timestamp.sv - bench for vita49_timestamp: directed table, corner sequences, random vs model
module tb_vita49_timestamp;
   localparam int SYNC    = 2;
   localparam int TIMEOUT = 150;

   localparam int LK_NONE   = 0;
   localparam int LK_ONE    = 1;
   localparam int LK_LOCKED = 2;
   localparam int LK_HOLD   = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic pps = 1'b0;
   logic samp = 1'b0;
   logic rstn8 = 1'b0;
   logic samp8 = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   vita49_timestamp_if #(.TSI_WIDTH(32), .TSF_WIDTH(64)) ts_if ();
   vita49_timestamp_if #(.TSI_WIDTH(32), .TSF_WIDTH(8))  ts8 ();

   vita49_timestamp #(
      .TSI_WIDTH(32), .TSF_WIDTH(64), .SYNC_STAGES(SYNC), .PPS_TIMEOUT(TIMEOUT)
   ) dut (
      .axis_clk(clk), .axis_aresetn(rstn), .pps_in(pps), .samp_en(samp), .ts(ts_if)
   );

   vita49_timestamp #(
      .TSI_WIDTH(32), .TSF_WIDTH(8), .SYNC_STAGES(SYNC), .PPS_TIMEOUT(TIMEOUT)
   ) dut8 (
      .axis_clk(clk), .axis_aresetn(rstn8), .pps_in(1'b0), .samp_en(samp8), .ts(ts8)
   );

   always #5 clk = ~clk;

   // Reference model state: seconds, samples, pending load, lock level, PPS sample history.
   logic [31:0] m_tsi = '0;
   logic [63:0] m_tsf = '0;
   logic [31:0] m_pend = '0;
   bit          m_pending = 0;
   bit          m_pulse = 0;
   bit          m_missed = 0;
   int          m_lock = LK_NONE;
   int          m_since = 0;
   bit          m_hist[$];

   typedef struct {
      int          cycles;
      logic        pps;
      logic        ld;
      logic [31:0] data;
      logic [31:0] tsi;
      logic [63:0] tsf;
      logic        pulse;
      logic        missed;
      logic        locked;
      logic        valid;
      logic        pending;
   } vec_t;

   vec_t vecs[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(logic r, logic p_in, logic s, logic l, logic [31:0] d);
      bit edge_now, timed_out;
      if (!r) begin
         m_tsi = '0; m_tsf = '0; m_pend = '0; m_pending = 0;
         m_pulse = 0; m_missed = 0; m_lock = LK_NONE; m_since = 0;
         m_hist = {};
         for (int i = 0; i < SYNC + 2; i++) m_hist.push_back(1'b0);
         return;
      end
      m_hist.push_front(p_in);
      void'(m_hist.pop_back());
      // index i holds the pps_in level sampled i edges ago
      edge_now  = m_hist[SYNC] && !m_hist[SYNC+1];
      timed_out = !edge_now && (m_since + 1 == TIMEOUT);
      m_since   = edge_now ? 0 : ((m_since < TIMEOUT) ? m_since + 1 : TIMEOUT);
      m_pulse   = edge_now;
      m_missed  = 0;
      if (edge_now) begin
         m_tsi = m_pending ? m_pend : m_tsi + 32'd1;
         m_tsf = '0;
         m_pending = 0;
      end else if (s) begin
         m_tsf = m_tsf + 64'd1;
      end
      if (l) begin
         m_pend = d;
         m_pending = 1;
      end
      if (edge_now) begin
         m_lock = (m_lock == LK_NONE) ? LK_ONE : LK_LOCKED;
      end else if (timed_out) begin
         if (m_lock == LK_ONE) begin
            m_lock = LK_NONE; m_missed = 1;
         end else if (m_lock == LK_LOCKED) begin
            m_lock = LK_HOLD; m_missed = 1;
         end
      end
   endtask

   task automatic tick();
      logic r_c, p_c, s_c, l_c;
      logic [31:0] d_c;
      r_c = rstn; p_c = pps; s_c = samp; l_c = ts_if.tsi_load_valid; d_c = ts_if.tsi_load_data;
      @(posedge clk);
      model_step(r_c, p_c, s_c, l_c, d_c);
      #1;
      check("model_tsi", {32'd0, ts_if.tsi}, {32'd0, m_tsi});
      check("model_tsf", ts_if.tsf, m_tsf);
      check("model_flags",
            {59'd0, ts_if.pps_pulse, ts_if.pps_missed, ts_if.pps_locked, ts_if.ts_valid, ts_if.load_pending},
            {59'd0, m_pulse, m_missed, (m_lock == LK_LOCKED), (m_lock == LK_LOCKED || m_lock == LK_HOLD), m_pending});
   endtask

   task automatic run(int n, logic p);
      pps = p;
      repeat (n) tick();
   endtask

   task automatic load(logic [31:0] d);
      ts_if.tsi_load_valid = 1'b1;
      ts_if.tsi_load_data  = d;
      tick();
      ts_if.tsi_load_valid = 1'b0;
   endtask

   task automatic expect_ts(string name, logic [31:0] tsi, logic [63:0] tsf, logic pulse,
                            logic locked, logic valid, logic pending);
      check({name, "_tsi"}, {32'd0, ts_if.tsi}, {32'd0, tsi});
      check({name, "_tsf"}, ts_if.tsf, tsf);
      check({name, "_flags"},
            {60'd0, ts_if.pps_pulse, ts_if.pps_locked, ts_if.ts_valid, ts_if.load_pending},
            {60'd0, pulse, locked, valid, pending});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ts_if.tsi_load_valid = 1'b0;
      ts_if.tsi_load_data  = '0;
      ts8.tsi_load_valid   = 1'b0;
      ts8.tsi_load_data    = '0;

      // cycles pps ld data | tsi tsf pulse missed locked valid pending  (samp_en held high)
      vecs.push_back('{10, 0, 0, 32'h0,    32'h0,    64'd10,  0, 0, 0, 0, 0});
      vecs.push_back('{2,  1, 0, 32'h0,    32'h0,    64'd12,  0, 0, 0, 0, 0});
      vecs.push_back('{1,  1, 0, 32'h0,    32'h1,    64'd0,   1, 0, 0, 0, 0});
      vecs.push_back('{49, 1, 0, 32'h0,    32'h1,    64'd49,  0, 0, 0, 0, 0});
      vecs.push_back('{48, 0, 0, 32'h0,    32'h1,    64'd97,  0, 0, 0, 0, 0});
      vecs.push_back('{2,  1, 0, 32'h0,    32'h1,    64'd99,  0, 0, 0, 0, 0});
      vecs.push_back('{1,  1, 0, 32'h0,    32'h2,    64'd0,   1, 0, 1, 1, 0});
      vecs.push_back('{10, 1, 0, 32'h0,    32'h2,    64'd10,  0, 0, 1, 1, 0});
      vecs.push_back('{1,  0, 1, 32'h1000, 32'h2,    64'd11,  0, 0, 1, 1, 1});
      vecs.push_back('{1,  0, 1, 32'h2000, 32'h2,    64'd12,  0, 0, 1, 1, 1});
      vecs.push_back('{85, 0, 0, 32'h0,    32'h2,    64'd97,  0, 0, 1, 1, 1});
      vecs.push_back('{2,  1, 0, 32'h0,    32'h2,    64'd99,  0, 0, 1, 1, 1});
      vecs.push_back('{1,  1, 0, 32'h0,    32'h2000, 64'd0,   1, 0, 1, 1, 0});
      vecs.push_back('{49, 1, 0, 32'h0,    32'h2000, 64'd49,  0, 0, 1, 1, 0});
      vecs.push_back('{48, 0, 0, 32'h0,    32'h2000, 64'd97,  0, 0, 1, 1, 0});
      vecs.push_back('{2,  1, 0, 32'h0,    32'h2000, 64'd99,  0, 0, 1, 1, 0});
      vecs.push_back('{1,  1, 0, 32'h0,    32'h2001, 64'd0,   1, 0, 1, 1, 0});
      vecs.push_back('{149,0, 0, 32'h0,    32'h2001, 64'd149, 0, 0, 1, 1, 0});
      vecs.push_back('{1,  0, 0, 32'h0,    32'h2001, 64'd150, 0, 1, 0, 1, 0});
      vecs.push_back('{1,  0, 0, 32'h0,    32'h2001, 64'd151, 0, 0, 0, 1, 0});
      vecs.push_back('{2,  1, 0, 32'h0,    32'h2001, 64'd153, 0, 0, 0, 1, 0});
      vecs.push_back('{1,  1, 0, 32'h0,    32'h2002, 64'd0,   1, 0, 1, 1, 0});
      vecs.push_back('{50, 1, 0, 32'h0,    32'h2002, 64'd50,  0, 0, 1, 1, 0});

      rstn = 1'b0;
      run(3, 1'b0);
      expect_ts("reset", 32'h0, 64'd0, 0, 0, 0, 0);
      check("reset_missed", {63'd0, ts_if.pps_missed}, 64'd0);
      rstn = 1'b1;
      samp = 1'b1;

      foreach (vecs[i]) begin
         pps = vecs[i].pps;
         ts_if.tsi_load_valid = vecs[i].ld;
         ts_if.tsi_load_data  = vecs[i].data;
         repeat (vecs[i].cycles) tick();
         check($sformatf("vec%0d_tsi", i), {32'd0, ts_if.tsi}, {32'd0, vecs[i].tsi});
         check($sformatf("vec%0d_tsf", i), ts_if.tsf, vecs[i].tsf);
         check($sformatf("vec%0d_flags", i),
               {59'd0, ts_if.pps_pulse, ts_if.pps_missed, ts_if.pps_locked, ts_if.ts_valid, ts_if.load_pending},
               {59'd0, vecs[i].pulse, vecs[i].missed, vecs[i].locked, vecs[i].valid, vecs[i].pending});
      end
      ts_if.tsi_load_valid = 1'b0;

      // TSI wrap-around through all-ones
      pps = 1'b0;
      load(32'hFFFF_FFFF);
      run(40, 1'b0);
      run(3, 1'b1);
      expect_ts("wrap_max", 32'hFFFF_FFFF, 64'd0, 1, 1, 1, 0);
      run(10, 1'b1);
      run(40, 1'b0);
      run(3, 1'b1);
      expect_ts("wrap_zero", 32'h0, 64'd0, 1, 1, 1, 0);

      // load coinciding with PPS, nothing pending
      run(5, 1'b1);
      run(40, 1'b0);
      run(2, 1'b1);
      load(32'h55);
      expect_ts("coinc_nopend", 32'h1, 64'd0, 1, 1, 1, 1);
      run(5, 1'b1);
      run(40, 1'b0);
      run(3, 1'b1);
      expect_ts("coinc_nopend_apply", 32'h55, 64'd0, 1, 1, 1, 0);

      // load coinciding with PPS while another is pending
      pps = 1'b0;
      load(32'h77);
      run(40, 1'b0);
      run(2, 1'b1);
      load(32'h88);
      expect_ts("coinc_pend", 32'h77, 64'd0, 1, 1, 1, 1);
      run(5, 1'b1);
      run(40, 1'b0);
      run(3, 1'b1);
      expect_ts("coinc_pend_apply", 32'h88, 64'd0, 1, 1, 1, 0);

      // single-cycle reset while locked with a load pending
      pps = 1'b0;
      load(32'h99);
      run(10, 1'b0);
      check("prereset_pending", {62'd0, ts_if.load_pending, ts_if.pps_locked}, 64'd3);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      expect_ts("midreset", 32'h0, 64'd0, 0, 0, 0, 0);
      run(10, 1'b0);
      run(3, 1'b1);
      expect_ts("reacq_first", 32'h1, 64'd0, 1, 0, 0, 0);
      run(47, 1'b1);
      run(47, 1'b0);
      run(3, 1'b1);
      expect_ts("reacq_second", 32'h2, 64'd0, 1, 1, 1, 0);

      // 8-bit TSF wraps 255 -> 0 with no PPS
      rstn8 = 1'b0;
      tick();
      rstn8 = 1'b1;
      samp8 = 1'b1;
      repeat (255) tick();
      check("tsf8_255", {56'd0, ts8.tsf}, 64'd255);
      tick();
      check("tsf8_wrap", {56'd0, ts8.tsf}, 64'd0);
      repeat (44) tick();
      check("tsf8_44", {56'd0, ts8.tsf}, 64'd44);
      check("tsf8_tsi", {31'd0, ts8.ts_valid, ts8.tsi}, 64'd0);
      samp8 = 1'b0;

      // random PPS spacing, strobes, loads and occasional resets against the model
      for (int seg = 0; seg < 60; seg++) begin
         int hi, lo;
         hi = $urandom_range(12, 2);
         lo = $urandom_range(220, 1);
         for (int c = 0; c < hi + lo; c++) begin
            pps  = (c < hi);
            samp = $urandom_range(1, 0);
            ts_if.tsi_load_valid = ($urandom_range(29, 0) == 0);
            ts_if.tsi_load_data  = $urandom;
            rstn = ($urandom_range(399, 0) != 0);
            tick();
         end
      end
      rstn = 1'b1;
      ts_if.tsi_load_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vita49_timestamp.md
# vita49_timestamp

Sample-domain timestamp generator for the VITA-49 path. It synchronises an asynchronous PPS input and counts integer seconds (TSI) and fractional sample ticks (TSF). It tracks PPS lock, and presents the `tsi`/`tsf` pair that the packer stamps into outgoing context and data packets. It is the consumer of the PPS and sample clocks produced by the simulation clock generator, and it is the counterpart to the unpacker's timestamp extraction.

## Interface
Parameters:
- `TSI_WIDTH`, 32, integer-seconds counter width
- `TSF_WIDTH`, 64, fractional sample counter width
- `SYNC_STAGES`, 2, PPS synchroniser depth (minimum 2)
- `PPS_TIMEOUT`, 150, cycles without PPS before a miss is declared (minimum 2)

Ports:
- `axis_clk`  in  1  sole clock
- `axis_aresetn`  in  1  reset, synchronous, active-low
- `pps_in`  in  1  asynchronous PPS, rising edge significant
- `samp_en`  in  1  one-cycle sample strobe, advances TSF
- `tsi_load_valid`  in  1  request to preset TSI at next PPS
- `tsi_load_data`  in  TSI_WIDTH  TSI value to apply at next PPS
- `tsi`  out  TSI_WIDTH  integer seconds
- `tsf`  out  TSF_WIDTH  samples since last PPS
- `ts_valid`  out  1  timestamp trustworthy (LOCKED or HOLDOVER)
- `pps_locked`  out  1  state is LOCKED
- `pps_pulse`  out  1  one-cycle strobe per detected PPS edge
- `pps_missed`  out  1  one-cycle strobe on timeout
- `load_pending`  out  1  TSI load armed, not yet applied

## Operation
- **Synchroniser.** `pps_in` passes through `SYNC_STAGES` flops, then one history flop. A rising edge is detected as last stage 1 and history 0. This drives registered `pps_pulse`.
- **TSI load.** `tsi_load_valid` captures `tsi_load_data` into a pending register and sets `load_pending`.
  - A later load before the PPS overwrites the pending value; the last one wins.
  - `load_pending` clears on the PPS that applies the value.
- **Counters on a PPS pulse.**
  - `tsi` becomes the pending value if `load_pending`, otherwise `tsi+1`. It wraps from all-ones to 0.
  - `tsf` becomes 0.
- **Counters with no PPS.** `samp_en` increments `tsf`, wrapping modulo 2^TSF_WIDTH.
- **Simultaneous events.**
  - PPS and `samp_en` in the same cycle: `tsf` becomes 0. The strobe is absorbed.
  - PPS and `tsi_load_valid` in the same cycle: the PPS applies the previously pending value, or increments if none was pending. The new value becomes pending for the following PPS.
- **Period counter.** Cleared on each PPS, otherwise increments. It saturates at `PPS_TIMEOUT`. The timeout event is the single cycle in which it first reaches `PPS_TIMEOUT`.
- **State machine.** States are UNLOCKED, ACQUIRE, LOCKED, HOLDOVER.
  - UNLOCKED: PPS leads to ACQUIRE. Timeout has no effect (no `pps_missed`).
  - ACQUIRE: PPS leads to LOCKED. Timeout leads to UNLOCKED with a `pps_missed` pulse.
  - LOCKED: PPS stays in LOCKED. Timeout leads to HOLDOVER with a `pps_missed` pulse.
  - HOLDOVER: PPS leads to LOCKED. Timeout can occur only once, because the counter saturates, so HOLDOVER persists until a PPS.
  - During HOLDOVER, `tsf` keeps counting past the nominal second and `tsi` holds.
- **Output decode.** `ts_valid` = LOCKED or HOLDOVER. `pps_locked` = LOCKED.

## Timing
- **Reset.** On a clock edge with `axis_aresetn` low:
  - `tsi`, `tsf`, the pending register, `load_pending`, `pps_pulse`, `pps_missed`, `ts_valid`, `pps_locked`, the period counter and all synchroniser flops go to 0.
  - State goes to UNLOCKED.
  - Reset mid-second discards any pending load and all lock history.
- **PPS latency.** A `pps_in` rising edge first sampled at edge k gives `pps_pulse` high after edge k+SYNC_STAGES (3 cycles for the default).
  - `tsi`/`tsf` update on that same edge.
  - State change is visible on that same edge.
- **Pulse widths.** `pps_pulse` and `pps_missed` are high exactly one cycle.
- **Minimum PPS width.** `pps_in` must be high for at least 2 `axis_clk` cycles. A held-high level yields one pulse only.
- **Other latencies.** `tsf` increments one cycle after `samp_en`. `load_pending` rises one cycle after `tsi_load_valid`.
- **Timeout.** With no PPS, `pps_missed` asserts on the edge where the period counter reaches `PPS_TIMEOUT`, i.e. `PPS_TIMEOUT` cycles after the last `pps_pulse`.

## Test plan
- **Reset and acquisition.** Reset, then `samp_en` every cycle with PPS period 100 cycles.
  - Required: all outputs 0 during reset.
  - First pulse: ACQUIRE, `tsi`=1, `ts_valid`=0.
  - Second pulse: LOCKED, `tsi`=2, `tsf`=0.
  - `tsf` reaches 99 just before each subsequent pulse.
- **TSI load.** While LOCKED, load 0x1000 then 0x2000 within one second.
  - Required: next PPS sets `tsi`=0x2000 and `load_pending`=0.
  - Following PPS gives `tsi`=0x2001.
- **Holdover and recovery.** While LOCKED, stop PPS.
  - Required: `pps_missed` single pulse 150 cycles after the last pulse, `pps_locked`=0, `ts_valid`=1, `tsf` continues past 99.
  - Restart PPS: LOCKED on the first pulse, `tsf`=0.
- **Wrap-around.** Load `tsi`=0xFFFFFFFF.
  - Required: next PPS gives 0xFFFFFFFF, the following PPS gives 0.
  - With `TSF_WIDTH`=8 and no PPS, `tsf` wraps 255→0.
- **Simultaneous events and edge cases.**
  - PPS coincident with `samp_en` gives `tsf`=0.
  - PPS coincident with `tsi_load_valid` follows the stated pending rule.
  - A 1-cycle glitch-free `pps_in` held high 50 cycles produces exactly one `pps_pulse`.
- **Mid-operation reset.** Assert `axis_aresetn` low 1 cycle while LOCKED with a load pending.
  - Required: UNLOCKED, `load_pending`=0, `tsi`=`tsf`=0.
  - Re-acquisition proceeds as in the first scenario.
